coax_irq_controller: RTL and testbench

//  Latches coax RX/TX status events into sticky pending bits. Applies a mask and drives the single irq pin to the MCU.

---
 rtl/coax_irq_controller_pkg.sv | 17 +
 rtl/coax_irq_controller_holdoff.sv | 26 ++
 rtl/coax_irq_controller.sv | 129 ++++++++++++
 tb/tb_coax_irq_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_irq_controller_pkg.sv
// Shared interrupt bit positions, vector type and irq FSM state encoding for the coax irq controller.
// Status decoding and write-1-to-clear decoding on the control side use the same bit map.
package coax_irq_controller_pkg;
  localparam int IRQ_RX_DONE  = 0;
  localparam int IRQ_RX_ERROR = 1;
  localparam int IRQ_TX_DONE  = 2;
  localparam int IRQ_RX_STALE = 3;
  localparam int IRQ_WIDTH    = 4;

  typedef logic [IRQ_WIDTH-1:0] irq_vec_t;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_e;
endpackage

// File: rtl/coax_irq_controller_holdoff.sv
// Hold-off timer: i_load presets HOLDOFF_CYCLES, then counts down to zero and holds there.
// o_done is combinational from the count and is high whenever the count is zero; it has no backpressure.
module coax_irq_controller_holdoff #(
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_done
);
  localparam int W = $clog2(HOLDOFF_CYCLES + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(HOLDOFF_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/coax_irq_controller.sv
// Latches coax RX/TX events into sticky write-1-to-clear pending bits and drives a masked, registered irq.
// Event at cycle N: pending at N+1, irq at N+2. A low gap of at least HOLDOFF_CYCLES follows each irq drop.
module coax_irq_controller
  import coax_irq_controller_pkg::*;
#(
  parameter int       HOLDOFF_CYCLES = 16,
  parameter int       STALE_CYCLES   = 65536,
  parameter irq_vec_t MASK_RESET     = 4'b0011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_active,
  input  logic                 rx_error,
  input  logic                 rx_empty,
  input  logic                 tx_active,
  input  logic                 mask_load_strobe,
  input  logic [IRQ_WIDTH-1:0] mask_data,
  input  logic                 ack_strobe,
  input  logic [IRQ_WIDTH-1:0] ack_data,
  output logic [IRQ_WIDTH-1:0] pending,
  output logic [IRQ_WIDTH-1:0] mask,
  output logic                 irq
);
  localparam int            SW         = $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] STALE_FIRE = SW'(STALE_CYCLES - 1);
  localparam logic [SW-1:0] STALE_SAT  = SW'(STALE_CYCLES);

  logic       r_rx_active_q;
  logic       r_rx_error_q;
  logic       r_tx_active_q;
  logic [SW-1:0] r_stale_cnt;
  irq_vec_t   r_pending;
  irq_vec_t   r_mask;
  logic       r_irq;
  irq_state_e r_state;

  logic       w_stale_run;
  irq_vec_t   w_evt;
  irq_vec_t   w_pending_nxt;
  irq_vec_t   w_mask_nxt;
  logic       w_holdoff_load;
  logic       w_holdoff_done;

  assign w_stale_run = ~rx_empty & ~rx_active;

  // An error-terminated frame reports RX_ERROR only, never RX_DONE.
  always_comb begin
    w_evt               = '0;
    w_evt[IRQ_RX_DONE]  = r_rx_active_q & ~rx_active & ~rx_error;
    w_evt[IRQ_RX_ERROR] = ~r_rx_error_q & rx_error;
    w_evt[IRQ_TX_DONE]  = r_tx_active_q & ~tx_active;
    w_evt[IRQ_RX_STALE] = w_stale_run & (r_stale_cnt == STALE_FIRE);
  end

  assign w_pending_nxt  = w_evt | (r_pending & ~({IRQ_WIDTH{ack_strobe}} & ack_data));
  assign w_mask_nxt     = mask_load_strobe ? mask_data : r_mask;
  assign w_holdoff_load = (r_state == IRQ_ASSERT) && ~|(w_pending_nxt & w_mask_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_active_q <= 1'b0;
      r_rx_error_q  <= 1'b0;
      r_tx_active_q <= 1'b0;
      r_pending     <= '0;
      r_mask        <= MASK_RESET;
    end else begin
      r_rx_active_q <= rx_active;
      r_rx_error_q  <= rx_error;
      r_tx_active_q <= tx_active;
      r_pending     <= w_pending_nxt;
      r_mask        <= w_mask_nxt;
    end
  end

  // Counter parks one past the fire point so a stale episode reports only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stale_cnt <= '0;
    end else if (!w_stale_run) begin
      r_stale_cnt <= '0;
    end else if (r_stale_cnt != STALE_SAT) begin
      r_stale_cnt <= r_stale_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IRQ_IDLE;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (|(r_pending & r_mask)) begin
            r_state <= IRQ_ASSERT;
            r_irq   <= 1'b1;
          end
        end
        IRQ_ASSERT: begin
          if (w_holdoff_load) begin
            r_state <= IRQ_HOLDOFF;
            r_irq   <= 1'b0;
          end
        end
        IRQ_HOLDOFF: begin
          if (w_holdoff_done) begin
            r_state <= IRQ_IDLE;
          end
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  coax_irq_controller_holdoff #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .i_clk (clk),
    .i_rst (reset),
    .i_load(w_holdoff_load),
    .o_done(w_holdoff_done)
  );

  assign pending = r_pending;
  assign mask    = r_mask;
  assign irq     = r_irq;
endmodule

// File: tb/tb_coax_irq_controller.sv
// Directed stimulus pushes cycle-tagged expectations into a scoreboard queue;
// a negedge monitor pops and compares each entry when its cycle arrives.
module tb_coax_irq_controller;
  localparam int SIG_PEND = 0;
  localparam int SIG_MASK = 1;
  localparam int SIG_IRQ  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_active, rx_error, rx_empty, tx_active;
  logic       mask_load_strobe, ack_strobe;
  logic [3:0] mask_data, ack_data;
  logic [3:0] pending, mask;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  coax_irq_controller #(
    .HOLDOFF_CYCLES(16),
    .STALE_CYCLES  (8),
    .MASK_RESET    (4'b0011)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_active       (rx_active),
    .rx_error        (rx_error),
    .rx_empty        (rx_empty),
    .tx_active       (tx_active),
    .mask_load_strobe(mask_load_strobe),
    .mask_data       (mask_data),
    .ack_strobe      (ack_strobe),
    .ack_data        (ack_data),
    .pending         (pending),
    .mask            (mask),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_sig(input int sig);
    case (sig)
      SIG_PEND: return pending;
      SIG_MASK: return mask;
      default:  return {3'b000, irq};
    endcase
  endfunction

  task automatic exp_push(input int d, input int sig, input logic [3:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, dut_sig(sb[i].sig), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: slot for cyc %0d missed, now %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1;
    rx_active = 1'b1; rx_error = 1'b0; rx_empty = 1'b1; tx_active = 1'b0;
    mask_load_strobe = 1'b0; mask_data = 4'h0; ack_strobe = 1'b0; ack_data = 4'h0;

    // 1: reset values, then rx_active falling after release
    step(3);
    exp_push(0, SIG_PEND, 4'b0000, "rst_pending");
    exp_push(0, SIG_MASK, 4'b0011, "rst_mask");
    exp_push(0, SIG_IRQ,  4'b0000, "rst_irq");
    @(negedge clk); #1;
    reset = 1'b0;
    step(1);
    exp_push(0, SIG_PEND, 4'b0000, "t1_pend_pre");
    rx_active = 1'b0;
    exp_push(1, SIG_PEND, 4'b0001, "t1_pend_n1");
    exp_push(1, SIG_IRQ,  4'b0000, "t1_irq_n1");
    exp_push(2, SIG_IRQ,  4'b0001, "t1_irq_n2");
    step(2);
    ack_strobe = 1'b1; ack_data = 4'b0001;
    exp_push(1, SIG_PEND, 4'b0000, "t1_ack_pend");
    exp_push(1, SIG_IRQ,  4'b0000, "t1_ack_irq");
    step(1);
    ack_strobe = 1'b0;
    step(20);

    // 2: error mid-frame suppresses RX_DONE; ack opens a hold-off gap
    rx_active = 1'b1;
    step(1);
    rx_error = 1'b1;
    exp_push(1, SIG_PEND, 4'b0010, "t2_pend_err");
    exp_push(2, SIG_IRQ,  4'b0001, "t2_irq_err");
    step(1);
    rx_active = 1'b0;
    step(1);
    rx_error = 1'b0;
    exp_push(1, SIG_PEND, 4'b0010, "t2_no_rxdone");
    exp_push(1, SIG_IRQ,  4'b0001, "t2_irq_held");
    step(1);
    ack_strobe = 1'b1; ack_data = 4'b0010;
    exp_push(1, SIG_PEND, 4'b0000, "t2_ack_pend");
    step(1);
    ack_strobe = 1'b0;
    for (int k = 0; k < 16; k++) exp_push(k, SIG_IRQ, 4'b0000, "t2_holdoff_low");
    step(20);

    // 3: masked TX_DONE stays silent until unmasked
    tx_active = 1'b1;
    step(1);
    tx_active = 1'b0;
    exp_push(1, SIG_PEND, 4'b0100, "t3_pend_tx");
    exp_push(2, SIG_IRQ,  4'b0000, "t3_irq_masked");
    exp_push(3, SIG_IRQ,  4'b0000, "t3_irq_masked2");
    step(3);
    mask_load_strobe = 1'b1; mask_data = 4'b0100;
    exp_push(1, SIG_MASK, 4'b0100, "t3_mask_load");
    exp_push(1, SIG_IRQ,  4'b0000, "t3_irq_n1");
    exp_push(2, SIG_IRQ,  4'b0001, "t3_irq_unmask");
    step(1);
    mask_load_strobe = 1'b0;
    step(1);
    ack_strobe = 1'b1; ack_data = 4'b0100;
    exp_push(1, SIG_PEND, 4'b0000, "t3_ack_pend");
    exp_push(1, SIG_IRQ,  4'b0000, "t3_ack_irq");
    step(1);
    ack_strobe = 1'b0;
    mask_load_strobe = 1'b1; mask_data = 4'b0011;
    step(1);
    mask_load_strobe = 1'b0;
    step(20);

    // 4: event and ack on the same bit in the same cycle, event wins
    rx_active = 1'b1;
    step(1);
    rx_active = 1'b0;
    exp_push(2, SIG_IRQ, 4'b0001, "t4_irq_up");
    step(1);
    rx_active = 1'b1;
    step(1);
    rx_active = 1'b0;
    ack_strobe = 1'b1; ack_data = 4'b0001;
    exp_push(1, SIG_PEND, 4'b0001, "t4_pend_event_wins");
    exp_push(1, SIG_IRQ,  4'b0001, "t4_irq_stays");
    exp_push(2, SIG_IRQ,  4'b0001, "t4_irq_stays2");
    step(1);
    ack_strobe = 1'b0;
    step(1);
    ack_strobe = 1'b1; ack_data = 4'b0001;
    exp_push(1, SIG_PEND, 4'b0000, "t4_clear");
    step(1);
    ack_strobe = 1'b0;
    mask_load_strobe = 1'b1; mask_data = 4'b1000;
    step(1);
    mask_load_strobe = 1'b0;
    step(20);

    // 5: RX_STALE after 8 cycles, once per episode
    rx_empty = 1'b0;
    for (int k = 1; k < 8; k++) exp_push(k, SIG_PEND, 4'b0000, "t5_pend_pre");
    exp_push(8, SIG_PEND, 4'b1000, "t5_stale_fire");
    exp_push(9, SIG_IRQ,  4'b0001, "t5_stale_irq");
    step(29);
    ack_strobe = 1'b1; ack_data = 4'b1000;
    for (int k = 1; k <= 12; k++) exp_push(k, SIG_PEND, 4'b0000, "t5_no_refire");
    exp_push(1, SIG_IRQ, 4'b0000, "t5_ack_irq");
    step(1);
    ack_strobe = 1'b0;
    step(11);
    rx_empty = 1'b1;
    step(1);
    rx_empty = 1'b0;
    exp_push(7, SIG_PEND, 4'b0000, "t5_rearm_pre");
    exp_push(8, SIG_PEND, 4'b1000, "t5_rearm_fire");
    step(9);
    ack_strobe = 1'b1; ack_data = 4'b1000; rx_empty = 1'b1;
    exp_push(1, SIG_PEND, 4'b0000, "t5_clear");
    step(1);
    ack_strobe = 1'b0;
    mask_load_strobe = 1'b1; mask_data = 4'b0011;
    step(1);
    mask_load_strobe = 1'b0;
    step(20);

    // 6: event during hold-off, then async reset while asserted
    rx_active = 1'b1;
    step(1);
    rx_active = 1'b0;
    exp_push(2, SIG_IRQ, 4'b0001, "t6_irq_up");
    step(2);
    ack_strobe = 1'b1; ack_data = 4'b0001;
    exp_push(1, SIG_IRQ, 4'b0000, "t6_ack_irq");
    step(1);
    ack_strobe = 1'b0;
    step(1);
    rx_error = 1'b1;
    exp_push(1, SIG_PEND, 4'b0010, "t6_pend_in_holdoff");
    for (int k = 1; k <= 14; k++) exp_push(k, SIG_IRQ, 4'b0000, "t6_irq_held_low");
    exp_push(17, SIG_IRQ, 4'b0001, "t6_irq_after_holdoff");
    step(18);
    #1;
    check("t6_irq_before_rst", {3'b000, irq}, 4'b0001);
    reset = 1'b1;
    #1;
    check("t6_async_irq", {3'b000, irq}, 4'b0000);
    check("t6_async_pend", pending, 4'b0000);
    rx_error = 1'b0; rx_active = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    rx_active = 1'b0;
    exp_push(1, SIG_PEND, 4'b0001, "t6_post_rst_rxdone");
    exp_push(2, SIG_IRQ,  4'b0001, "t6_post_rst_irq");
    step(3);

    for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
